// File: rtl/sobel_pkg.sv
// Shared state encoding, default geometry and drain timing for the Sobel frame sequencer.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int DEF_IMG_W  = 256;
  localparam int DEF_IMG_H  = 256;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_PIX_W  = 8;

  // The Loader needs about two rows of slack after the last pixel before isEnd.
  function automatic int drain_limit(input int img_w);
    return 2 * img_w + 4;
  endfunction

endpackage

// File: rtl/sobel_addr_cnt.sv
// Enable-gated up-counter with synchronous clear and a terminal-count flag at LAST.
module sobel_addr_cnt #(
  parameter int W    = 17,
  parameter int LAST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == LAST_V);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: raster-fetches the input memory into the Loader and turns Loader windows into result writes.
// Optional drain watchdog enabled by defining SOBEL_DRAIN_TIMEOUT_EN.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [PIX_W-1:0]  RdData,
  output logic              LdEnable,
  output logic [PIX_W-1:0]  LdData,
  input  logic              LdReady,
  input  logic              LdEnd,
  input  logic [7:0]        LdRow,
  input  logic [7:0]        LdCol,
  input  logic              OutReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic              Error
);

  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int CNT_W     = ADDR_W + 1;

  state_t             state, state_nx;
  logic               rd_issue;
  logic               fetch_clr;
  logic               fetch_tc;
  logic               drain_timeout;
  logic [CNT_W-1:0]   fetch_cnt;
  logic [ADDR_W+7:0]  wr_lin;

  assign fetch_clr = (state == IDLE) && Start;

  // One extra bit so a full 2**ADDR_W frame reaches its terminal count without wrapping.
  sobel_addr_cnt #(
    .W    (CNT_W),
    .LAST (FRAME_PIX - 1)
  ) u_fetch_cnt (
    .clk (CLK),
    .rst (Reset),
    .clr (fetch_clr),
    .en  (rd_issue),
    .cnt (fetch_cnt),
    .tc  (fetch_tc)
  );

`ifdef SOBEL_DRAIN_TIMEOUT_EN
  localparam int DRAIN_W = $clog2(drain_limit(IMG_W) + 1);

  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_tc;
  logic               drain_clr;
  logic               drain_en;

  assign drain_clr = (state != DRAIN);
  assign drain_en  = (state == DRAIN);

  sobel_addr_cnt #(
    .W    (DRAIN_W),
    .LAST (drain_limit(IMG_W) - 1)
  ) u_drain_cnt (
    .clk (CLK),
    .rst (Reset),
    .clr (drain_clr),
    .en  (drain_en),
    .cnt (drain_cnt),
    .tc  (drain_tc)
  );

  // A late LdEnd on the final allowed cycle still counts as a clean finish.
  assign drain_timeout = (state == DRAIN) && drain_tc && !LdEnd;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      Error <= 1'b0;
    end else if (drain_timeout) begin
      Error <= 1'b1;
    end
  end
`else
  assign drain_timeout = 1'b0;
  assign Error         = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    rd_issue = 1'b0;
    unique case (state)
      IDLE:  if (Start) state_nx = FETCH;
      FETCH: begin
        rd_issue = OutReady;
        if (OutReady && fetch_tc) state_nx = DRAIN;
      end
      DRAIN: if (LdEnd || drain_timeout) state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Widened before truncation so LdRow*IMG_W cannot overflow early.
  assign wr_lin = (ADDR_W+8)'(LdRow) * (ADDR_W+8)'(IMG_W) + (ADDR_W+8)'(LdCol);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      RdEn     <= 1'b0;
      RdAddr   <= '0;
      LdEnable <= 1'b0;
      LdData   <= '0;
      WrEn     <= 1'b0;
      WrAddr   <= '0;
    end else begin
      state    <= state_nx;
      Busy     <= (state_nx == FETCH) || (state_nx == DRAIN);
      Done     <= (state_nx == FIN);
      RdEn     <= rd_issue;
      if (rd_issue) RdAddr <= ADDR_W'(fetch_cnt);
      LdEnable <= RdEn;
      if (LdEnable) LdData <= RdData;
      WrEn     <= LdReady && LdEnable;
      WrAddr   <= ADDR_W'(wr_lin);
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on a 4x4 frame with mem[i] = i + 10.
module tb_sobel_frame_ctrl;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 16;
  localparam int PIX_W  = 8;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              CLK;
  logic              Reset;
  logic              Start;
  logic              Busy;
  logic              Done;
  logic              RdEn;
  logic [ADDR_W-1:0] RdAddr;
  logic [PIX_W-1:0]  RdData;
  logic              LdEnable;
  logic [PIX_W-1:0]  LdData;
  logic              LdReady;
  logic              LdEnd;
  logic [7:0]        LdRow;
  logic [7:0]        LdCol;
  logic              OutReady;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic              Error;

  sobel_frame_ctrl #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .Busy     (Busy),
    .Done     (Done),
    .RdEn     (RdEn),
    .RdAddr   (RdAddr),
    .RdData   (RdData),
    .LdEnable (LdEnable),
    .LdData   (LdData),
    .LdReady  (LdReady),
    .LdEnd    (LdEnd),
    .LdRow    (LdRow),
    .LdCol    (LdCol),
    .OutReady (OutReady),
    .WrEn     (WrEn),
    .WrAddr   (WrAddr),
    .Error    (Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [PIX_W-1:0]  mem [0:NPIX-1];
  logic [ADDR_W-1:0] rd_q [$];
  logic [PIX_W-1:0]  ld_q [$];
  logic [ADDR_W-1:0] wr_q [$];
  int                done_q [$];

  logic prev_rd_en, prev_ld_en, prev_done;
  int   ld_en_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got an event or timeout where none was expected", nm);
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({Busy, Done, RdEn, RdAddr, LdEnable, LdData, WrEn, WrAddr, Error});
  endfunction

  // Synchronous input memory: data valid the cycle after RdEn.
  always @(posedge CLK) begin
    if (Reset) RdData <= '0;
    else if (RdEn) RdData <= mem[RdAddr[3:0]];
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(posedge CLK) begin
    #1;
    if (Reset) begin
      prev_rd_en = 1'b0;
      prev_ld_en = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (RdEn) begin
        if (rd_q.size() == 0) miss("rd_unexpected");
        else check("rd_addr", RdAddr, rd_q.pop_front());
      end
      if (LdEnable || prev_rd_en) check("ld_enable_lag", LdEnable, prev_rd_en);
      if (prev_ld_en) begin
        if (ld_q.size() == 0) miss("ld_unexpected");
        else check("ld_data", LdData, ld_q.pop_front());
      end
      if (WrEn) begin
        if (wr_q.size() == 0) miss("wr_unexpected");
        else check("wr_addr", WrAddr, wr_q.pop_front());
      end
      if (Done) begin
        if (done_q.size() == 0) miss("done_unexpected");
        else begin
          void'(done_q.pop_front());
          check("done_busy", Busy, 0);
          check("done_width", prev_done, 0);
        end
      end
      if (LdEnable) ld_en_cnt++;
      prev_rd_en = RdEn;
      prev_ld_en = LdEnable;
      prev_done  = Done;
    end
  end

  task automatic start_frame();
    Start = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      rd_q.push_back(ADDR_W'(i));
      ld_q.push_back(PIX_W'(i + 10));
    end
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic wait_rd(input logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    while (!(RdEn && RdAddr == a) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (!(RdEn && RdAddr == a)) miss("wait_rd_timeout");
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((rd_q.size() != 0 || ld_q.size() != 0) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (rd_q.size() != 0 || ld_q.size() != 0) miss("drain_timeout");
  endtask

  task automatic finish_frame();
    LdEnd = 1'b1;
    done_q.push_back(1);
    @(negedge CLK);
    LdEnd = 1'b0;
    check("fin_done", Done, 1);
    check("fin_busy", Busy, 0);
    check("fin_error", Error, 0);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check("done_cleared", Done, 0);
    check("fin_start_ignored", Busy, 0);
    @(negedge CLK);
    check("idle_after_fin", Busy, 0);
    check("writes_consumed", wr_q.size(), 0);
  endtask

  logic [7:0]        w_row [4] = '{8'd2, 8'd1, 8'd3, 8'd255};
  logic [7:0]        w_col [4] = '{8'd3, 8'd0, 8'd3, 8'd255};
  logic [ADDR_W-1:0] w_exp [4] = '{16'd11, 16'd4, 16'd15, 16'd1275};

  initial begin
    int n;
    int ld0;
    for (int i = 0; i < NPIX; i++) mem[i] = PIX_W'(i + 10);
    Reset = 1'b1; Start = 1'b0; OutReady = 1'b1;
    LdReady = 1'b0; LdEnd = 1'b0; LdRow = '0; LdCol = '0;
    repeat (3) @(negedge CLK);
    check("reset_outs", outs_vec(), 0);
    Reset = 1'b0;
    @(negedge CLK);
    check("idle_busy", Busy, 0);

    // Frame A: nominal stream, write mapping, Start and LdEnd ignored while fetching.
    start_frame();
    check("busy_after_start", Busy, 1);
    n = 0;
    while (!LdEnable && n < 10) begin @(negedge CLK); n++; end
    if (!LdEnable) miss("ld_enable_timeout");
    for (int i = 0; i < 4; i++) begin
      LdReady = 1'b1; LdRow = w_row[i]; LdCol = w_col[i];
      wr_q.push_back(w_exp[i]);
      @(negedge CLK);
    end
    LdReady = 1'b0;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check("busy_start_ignored", Busy, 1);
    LdEnd = 1'b1;
    @(negedge CLK);
    LdEnd = 1'b0;
    wait_drained();
    LdReady = 1'b1; LdRow = 8'd1; LdCol = 8'd1;
    @(negedge CLK);
    LdReady = 1'b0;
    finish_frame();

    // Frame B: three-cycle backpressure at RdAddr 5.
    ld0 = ld_en_cnt;
    start_frame();
    wait_rd(16'd5);
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("stall_rden", RdEn, 0);
      check("stall_addr", RdAddr, 5);
    end
    OutReady = 1'b1;
    wait_drained();
    check("ld_enable_cycles", ld_en_cnt - ld0, NPIX);
    finish_frame();

    // Frame C: reset mid-frame, then restart from address 0.
    start_frame();
    wait_rd(16'd7);
    Reset = 1'b1;
    rd_q.delete(); ld_q.delete(); wr_q.delete();
    repeat (3) @(negedge CLK);
    check("midrun_reset_outs", outs_vec(), 0);
    Reset = 1'b0;
    @(negedge CLK);
    check("post_reset_busy", Busy, 0);
    start_frame();
    check("restart_busy", Busy, 1);
    wait_drained();
    finish_frame();

`ifdef SOBEL_DRAIN_TIMEOUT_EN
    // Frame D: LdEnd never arrives; watchdog ends the frame.
    start_frame();
    done_q.push_back(1);
    wait_rd(16'd15);
    n = 0;
    while (!Done && n < 40) begin @(negedge CLK); n++; end
    check("timeout_cycles", n, 12);
    check("timeout_error", Error, 1);
    repeat (4) @(negedge CLK);
    check("error_sticky", Error, 1);
    Reset = 1'b1;
    @(negedge CLK);
    check("error_reset", Error, 0);
    Reset = 1'b0;
    @(negedge CLK);
`endif

    check("rd_q_empty", rd_q.size(), 0);
    check("ld_q_empty", ld_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
